// File: rtl/seg_scan_pkg.sv
// Shared constants and sizing helper for the segment scan multiplexer.
package seg_scan_pkg;

  localparam int SEG_W = 8;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

  // Minimum width of 1 keeps single-digit and tiny-divider builds legal.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot timer for the scan multiplexer: divides clk into digit slots and
// flags the blanking window and the start of each frame.
module seg_scan_timer
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  localparam int DIV_W       = clog2(REFRESH_DIV),
  localparam int IDX_W       = clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             in_blank,
  output logic [IDX_W-1:0] slot_idx,
  output logic             frame_start
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [IDX_W-1:0] dig_idx;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_cnt <= '0;
      dig_idx <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      dig_idx <= (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
      assign in_blank = (div_cnt < BLANK_END);
    end
  endgenerate

  assign slot_idx    = dig_idx;
  assign frame_start = (div_cnt == '0) && (dig_idx == '0);

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexes NUM_DIGITS segment patterns onto one bus with blanking and
// a per-frame input snapshot. Optional macro SEG_SCAN_DIM_EN adds PWM dimming.
module seg_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [SEG_W*NUM_DIGITS-1:0] seg_in,
`ifdef SEG_SCAN_DIM_EN
  input  logic [3:0]                  bright,
`endif
  output logic [SEG_W-1:0]            seg_out,
  output logic [NUM_DIGITS-1:0]       dig_en,
  output logic                        frame_tick
);

  localparam int IDX_W = clog2(NUM_DIGITS);

  logic                        in_blank;
  logic [IDX_W-1:0]            slot_idx;
  logic                        frame_start;
  logic [SEG_W*NUM_DIGITS-1:0] snap;
  logic [SEG_W*NUM_DIGITS-1:0] snap_next;
  logic [SEG_W-1:0]            drive_seg;
  logic [NUM_DIGITS-1:0]       drive_dig;
  logic                        pwm_on;

  seg_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_blank   (in_blank),
    .slot_idx   (slot_idx),
    .frame_start(frame_start)
  );

  // Bypass the snapshot register on the load edge so a zero-blank slot 0
  // shows the new frame immediately.
  always_comb begin
    snap_next = frame_start ? seg_in : snap;
    drive_seg = snap_next[slot_idx*SEG_W +: SEG_W];
    drive_dig = NUM_DIGITS'(1) << slot_idx;
  end

`ifdef SEG_SCAN_DIM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign pwm_on = (bright == 4'hF) || (pwm_cnt < bright);
`else
  assign pwm_on = 1'b1;
`endif

  // Output stage: one cycle behind the timer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap       <= '0;
      seg_out    <= SEG_BLANK;
      dig_en     <= '0;
      frame_tick <= 1'b0;
    end else if (!en) begin
      seg_out    <= SEG_BLANK;
      dig_en     <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_start;
      if (frame_start) snap <= seg_in;
      if (in_blank || !pwm_on) begin
        seg_out <= SEG_BLANK;
        dig_en  <= '0;
      end else begin
        seg_out <= drive_seg;
        dig_en  <= drive_dig;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux (4 digits, 8-cycle slots, 2 blank cycles): scoreboard
// of expected outputs plus a per-slot vector table and corner-case sequences.
module tb_seg_scan_mux;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [31:0] seg_in = '0;
  logic [7:0]  seg_out;
  logic [3:0]  dig_en;
  logic        frame_tick;
`ifdef SEG_SCAN_DIM_EN
  logic [3:0]  bright = 4'hF;
`endif

  seg_scan_mux #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .seg_in    (seg_in),
`ifdef SEG_SCAN_DIM_EN
    .bright    (bright),
`endif
    .seg_out   (seg_out),
    .dig_en    (dig_en),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       tick;
    logic [3:0] dig;
    logic [7:0] seg;
  } obs_t;

  typedef struct {
    logic [31:0] seg_in;
    int          slot;
    logic [7:0]  seg;
    logic [3:0]  dig;
  } vec_t;

  obs_t        sb_q[$];
  vec_t        tbl[4];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          t     = 0;
  int          cyc   = 0;
  logic [31:0] msnap = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Expected output is derived from the frame position t of each enabled edge.
  task automatic step(input logic r, input logic e, input logic [31:0] s);
    obs_t x;
    obs_t got;
    @(negedge clk);
    rst    = r;
    en     = e;
    seg_in = s;
    x = '0;
    if (r) begin
      msnap = '0;
      t = 0;
    end else if (!e) begin
      t = 0;
    end else begin
      int p;
      int slot;
      int off;
      p    = t % FRAME;
      slot = p / RD;
      off  = p % RD;
      x.tick = (p == 0);
      if (p == 0) msnap = s;
      if (off >= BC) begin
        x.seg = msnap[slot*8 +: 8];
        x.dig = 4'(1 << slot);
      end
      t++;
    end
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    got = {frame_tick, dig_en, seg_out};
    x = sb_q.pop_front();
    check($sformatf("cycle%0d {tick,dig,seg}", cyc), 32'(got), 32'(x));
    n_cmp++;
    if ($countones(dig_en) > 1) begin
      n_bad++;
      $display("FAIL onehot cycle%0d: got %b, want at most one bit", cyc, dig_en);
    end
    cyc++;
  endtask

  initial begin
    tbl[0] = '{32'hF2DA60FC, 0, 8'hFC, 4'b0001};
    tbl[1] = '{32'hF2DA60FC, 1, 8'h60, 4'b0010};
    tbl[2] = '{32'hF2DA60FC, 2, 8'hDA, 4'b0100};
    tbl[3] = '{32'hF2DA60FC, 3, 8'hF2, 4'b1000};

    // Reset held three cycles, then one idle cycle after release.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'hFFFF_FFFF);
    step(1'b0, 1'b0, 32'hF2DA60FC);
    check("post_reset_out", {23'd0, frame_tick, dig_en, seg_out}, 32'd0);

    // Two full frames checked against the slot table.
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 4; k++) begin
        for (int off = 0; off < RD; off++) begin
          step(1'b0, 1'b1, tbl[k].seg_in);
          check($sformatf("tbl_tick f%0d s%0d o%0d", f, k, off), 32'(frame_tick),
                32'((k == 0) && (off == 0)));
          if (off < BC)
            check($sformatf("tbl_blank f%0d s%0d o%0d", f, k, off), {20'd0, dig_en, seg_out}, 32'd0);
          else
            check($sformatf("tbl_drive f%0d s%0d o%0d", f, tbl[k].slot, off),
                  {20'd0, dig_en, seg_out}, {20'd0, tbl[k].dig, tbl[k].seg});
        end
      end
    end

    // Digit 1 changes mid-frame; visible only after the next snapshot.
    for (int p = 0; p < FRAME; p++) begin
      step(1'b0, 1'b1, (p < 12) ? 32'hF2DA60FC : 32'hF2DAB6FC);
      if (p == 13) check("mid_frame_hold", 32'(seg_out), 32'h60);
    end
    for (int p = 0; p < FRAME; p++) begin
      step(1'b0, 1'b1, 32'hF2DAB6FC);
      if (p == 13) check("next_frame_new", 32'(seg_out), 32'hB6);
    end

    // Drop en during digit 2 drive, restart five cycles later.
    for (int p = 0; p < 20; p++) step(1'b0, 1'b1, 32'hF2DAB6FC);
    check("pre_drop_dig2", 32'(dig_en), 32'h4);
    step(1'b0, 1'b0, 32'hF2DAB6FC);
    check("en_drop_zero", {23'd0, frame_tick, dig_en, seg_out}, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'hF2DAB6FC);
    step(1'b0, 1'b1, 32'hF2DAB6FC);
    check("restart_tick", {27'd0, frame_tick, dig_en}, 32'h10);
    step(1'b0, 1'b1, 32'hF2DAB6FC);
    step(1'b0, 1'b1, 32'hF2DAB6FC);
    check("restart_dig0", {20'd0, dig_en, seg_out}, 32'h1FC);
    for (int p = 3; p < FRAME; p++) step(1'b0, 1'b1, 32'hF2DAB6FC);

    // Reset during digit 3 drive; restart snapshot replaces zeroed snap.
    step(1'b0, 1'b0, 32'hF2DAB6FC);
    for (int p = 0; p < 29; p++) step(1'b0, 1'b1, 32'hF2DAB6FC);
    check("pre_rst_dig3", {20'd0, dig_en, seg_out}, 32'h8F2);
    step(1'b1, 1'b1, 32'hF2DAB6FC);
    check("mid_rst_zero", {23'd0, frame_tick, dig_en, seg_out}, 32'd0);
    step(1'b0, 1'b1, 32'h12345678);
    check("rst_restart_tick", 32'(frame_tick), 32'd1);
    step(1'b0, 1'b1, 32'h12345678);
    step(1'b0, 1'b1, 32'h12345678);
    check("rst_restart_dig0", {20'd0, dig_en, seg_out}, 32'h178);
    for (int p = 3; p < FRAME + 1; p++) step(1'b0, 1'b1, 32'h12345678);
    check("second_frame_tick", 32'(frame_tick), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
